// File: rtl/datapath_pkg.sv
// Shared encodings for the parametrised datapath: ALU opcodes, shifter codes,
// write-data select constants and the multiplier FSM state type.
package datapath_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_MVN  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_MUL  = 3'b110;
    localparam logic [2:0] ALU_ZERO = 3'b111;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [3:0] VSEL_MDATA = 4'b1000;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_C     = 4'b0001;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_RUN  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/datapath_param_if.sv
// Control/data bundle between the controller (master) and the datapath (slave).
interface datapath_param_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PC_W  = 9
);
    import datapath_pkg::*;

    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [RW-1:0]    readnum;
    logic [RW-1:0]    writenum;
    logic             write;
    logic [3:0]       vsel;
    logic             loada;
    logic             loadb;
    logic             asel;
    logic             bsel;
    logic [1:0]       shift;
    logic [2:0]       ALUop;
    logic             loadc;
    logic             loads;
    logic [WIDTH-1:0] sximm8;
    logic [WIDTH-1:0] sximm5;
    logic [WIDTH-1:0] mdata;
    logic [PC_W-1:0]  PC;
    logic [WIDTH-1:0] datapath_out;
    logic             Z_out;
    logic             N_out;
    logic             V_out;
    logic             busy;
    logic             done;

    modport master (
        output readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, sximm8, sximm5, mdata, PC,
        input  datapath_out, Z_out, N_out, V_out, busy, done
    );

    modport slave (
        input  readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, sximm8, sximm5, mdata, PC,
        output datapath_out, Z_out, N_out, V_out, busy, done
    );

endinterface

// File: rtl/datapath_param_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// o_fin marks the final step; o_product_lo/o_ovf are the value being
// committed on that step so the owner can capture it on the same edge.
module seq_mul
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fin,
    output logic [WIDTH-1:0] o_product_lo,
    output logic             o_ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_t         r_state;
    mul_state_t         w_state_nxt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_done;
    logic               w_last;

    assign w_last    = (r_state == MS_RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    // State register; reset aborts any multiply in flight
    always_ff @(posedge clk) begin
        if (reset) r_state <= MS_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: start from IDLE, leave RUN after the last step
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MS_IDLE: if (i_start) w_state_nxt = MS_RUN;
            MS_RUN:  if (w_last)  w_state_nxt = MS_IDLE;
        endcase
    end

    // Operand capture and one shift-add step per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if ((r_state == MS_IDLE) && i_start) begin
                r_mcand  <= {{WIDTH{1'b0}}, i_op_a};
                r_mplier <= i_op_b;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == MS_RUN) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
        end
    end

    assign o_busy       = (r_state == MS_RUN);
    assign o_done       = r_done;
    assign o_fin        = w_last;
    assign o_product_lo = w_acc_nxt[WIDTH-1:0];
    assign o_ovf        = |w_acc_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/datapath_param.sv
// Parametrised datapath: register file, A/B/C registers, shifter, ALU,
// Z/N/V status and an iterative multiplier with busy/done handshake.
module datapath_param
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int PC_W  = 9
) (
    input  logic            clk,
    input  logic            reset,
    datapath_param_if.slave dp
);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic             r_z;
    logic             r_n;
    logic             r_v;
    logic             r_mul_loads;

    logic [WIDTH-1:0] w_data_in;
    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] w_bsh;
    logic [WIDTH-1:0] w_ain;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_alu;
    logic             w_v;
    logic             w_mul_start;
    logic             w_c_load;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic             w_mul_fin;
    logic             w_mul_ovf;
    logic [WIDTH-1:0] w_mul_lo;

    // Write-data select; anything that is not one-hot writes zero
    always_comb begin
        case (dp.vsel)
            VSEL_MDATA: w_data_in = dp.mdata;
            VSEL_IMM8:  w_data_in = dp.sximm8;
            VSEL_PC:    w_data_in = WIDTH'(dp.PC);
            VSEL_C:     w_data_in = r_c;
            default:    w_data_in = '0;
        endcase
    end

    // Register file write port; read port is combinational (old value on collision)
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (dp.write) begin
            r_regs[dp.writenum] <= w_data_in;
        end
    end

    assign w_rd = r_regs[dp.readnum];

    // Operand registers load from the read port, also while a multiply runs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (dp.loada) r_a <= w_rd;
            if (dp.loadb) r_b <= w_rd;
        end
    end

    // Shifter on the B path
    always_comb begin
        case (dp.shift)
            SH_PASS: w_bsh = r_b;
            SH_LSL:  w_bsh = {r_b[WIDTH-2:0], 1'b0};
            SH_LSR:  w_bsh = {1'b0, r_b[WIDTH-1:1]};
            default: w_bsh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
        endcase
    end

    assign w_ain = dp.asel ? '0 : r_a;
    assign w_bin = dp.bsel ? dp.sximm5 : w_bsh;

    // Single-cycle ALU; MUL is produced by seq_mul, code 111 yields zero
    always_comb begin
        w_alu = '0;
        w_v   = 1'b0;
        case (dp.ALUop)
            ALU_ADD: begin
                w_alu = w_ain + w_bin;
                w_v   = (w_ain[WIDTH-1] == w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
            end
            ALU_SUB: begin
                w_alu = w_ain - w_bin;
                w_v   = (w_ain[WIDTH-1] != w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
            end
            ALU_AND: w_alu = w_ain & w_bin;
            ALU_MVN: w_alu = ~w_bin;
            ALU_OR:  w_alu = w_ain | w_bin;
            ALU_XOR: w_alu = w_ain ^ w_bin;
            default: w_alu = '0;
        endcase
    end

    assign w_mul_start = dp.loadc && (dp.ALUop == ALU_MUL) && !w_mul_busy;
    assign w_c_load    = dp.loadc && (dp.ALUop != ALU_MUL) && !w_mul_busy;

    seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .reset        (reset),
        .i_start      (w_mul_start),
        .i_op_a       (w_ain),
        .i_op_b       (w_bin),
        .o_busy       (w_mul_busy),
        .o_done       (w_mul_done),
        .o_fin        (w_mul_fin),
        .o_product_lo (w_mul_lo),
        .o_ovf        (w_mul_ovf)
    );

    // Result and status: multiply completion or an idle single-cycle op
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c         <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_mul_loads <= 1'b0;
        end else begin
            if (w_mul_start) r_mul_loads <= dp.loads;
            if (w_mul_fin) begin
                r_c <= w_mul_lo;
                if (r_mul_loads) begin
                    r_z <= (w_mul_lo == '0);
                    r_n <= w_mul_lo[WIDTH-1];
                    r_v <= w_mul_ovf;
                end
            end else if (w_c_load) begin
                r_c <= w_alu;
                if (dp.loads) begin
                    r_z <= (w_alu == '0);
                    r_n <= w_alu[WIDTH-1];
                    r_v <= w_v;
                end
            end
        end
    end

    assign dp.datapath_out = r_c;
    assign dp.Z_out        = r_z;
    assign dp.N_out        = r_n;
    assign dp.V_out        = r_v;
    assign dp.busy         = w_mul_busy;
    assign dp.done         = w_mul_done;

endmodule

// File: tb/tb_datapath_param.sv
// Self-checking bench for datapath_param: expected results are queued when
// an operation is issued and popped when the DUT result is visible.
module tb_datapath_param;
    import datapath_pkg::*;

    localparam int W  = 16;
    localparam int NR = 8;
    localparam int PW = 9;

    typedef struct packed {
        logic [W-1:0] c;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    datapath_param_if #(.WIDTH(W), .NREGS(NR), .PC_W(PW)) dp ();

    datapath_param #(.WIDTH(W), .NREGS(NR), .PC_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .dp    (dp)
    );

    // ---------------- drive helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [3:0] vs);
        dp.writenum = 3'(idx);
        dp.vsel     = vs;
        dp.write    = 1'b1;
        tick();
        dp.write    = 1'b0;
        dp.vsel     = '0;
    endtask

    task automatic lda(input int idx);
        dp.readnum = 3'(idx);
        dp.loada   = 1'b1;
        tick();
        dp.loada   = 1'b0;
    endtask

    task automatic ldb(input int idx);
        dp.readnum = 3'(idx);
        dp.loadb   = 1'b1;
        tick();
        dp.loadb   = 1'b0;
    endtask

    task automatic op(input logic [2:0] aop, input logic [1:0] sh,
                      input logic as, input logic bs, input logic ld);
        dp.ALUop = aop;
        dp.shift = sh;
        dp.asel  = as;
        dp.bsel  = bs;
        dp.loads = ld;
        dp.loadc = 1'b1;
        tick();
        dp.loadc = 1'b0;
        dp.loads = 1'b0;
    endtask

    // C <- Rn via A + 0
    task automatic rd_to_c(input int idx);
        lda(idx);
        dp.sximm5 = '0;
        op(ALU_ADD, SH_PASS, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] aop, input logic [1:0] sh,
                                           input logic as, input logic bs,
                                           input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] imm);
        logic [W-1:0] x, y;
        case (sh)
            2'b00:   y = b;
            2'b01:   y = b << 1;
            2'b10:   y = b >> 1;
            default: y = W'($signed(b) >>> 1);
        endcase
        if (bs) y = imm;
        x = as ? '0 : a;
        case (aop)
            ALU_ADD: return x + y;
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_MVN: return ~y;
            ALU_OR:  return x | y;
            ALU_XOR: return x ^ y;
            default: return '0;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < NR; i++) begin
            dp.mdata = W'($urandom) | 16'h8001;
            wr(i, VSEL_MDATA);
        end
        lda(1);
        ldb(2);
        op(ALU_SUB, SH_PASS, 1'b0, 1'b0, 1'b1);
        op(ALU_MUL, SH_PASS, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (dp.datapath_out !== '0) begin
            bad++;
            $display("FAIL reset_c got=%h exp=0000", dp.datapath_out);
        end
        total++;
        if ({dp.Z_out, dp.N_out, dp.V_out} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000", {dp.Z_out, dp.N_out, dp.V_out});
        end
        total++;
        if ({dp.busy, dp.done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_busy_done got=%b exp=00", {dp.busy, dp.done});
        end
        for (int i = 0; i < NR; i++) begin
            exp_q.push_back('{c: '0, z: 1'b0, n: 1'b0, v: 1'b0});
            rd_to_c(i);
            e = exp_q.pop_front();
            total++;
            if (dp.datapath_out !== e.c) begin
                bad++;
                $display("FAIL reset_R%0d got=%h exp=%h", i, dp.datapath_out, e.c);
            end
        end
    endtask

    task automatic test_vsel();
        exp_t e;
        logic [W-1:0] expv [6];
        dp.mdata  = 16'd54;
        dp.sximm8 = 16'd72;
        dp.PC     = 9'd20;
        wr(1, VSEL_MDATA);
        wr(2, VSEL_IMM8);
        wr(3, VSEL_PC);
        wr(5, VSEL_MDATA);
        rd_to_c(2);
        wr(4, VSEL_C);
        wr(5, 4'b0011);
        expv = '{16'd0, 16'd54, 16'd72, 16'd20, 16'd72, 16'd0};
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back('{c: expv[i], z: 1'b0, n: 1'b0, v: 1'b0});
            rd_to_c(i);
            e = exp_q.pop_front();
            total++;
            if (dp.datapath_out !== e.c) begin
                bad++;
                $display("FAIL vsel_R%0d got=%h exp=%h", i, dp.datapath_out, e.c);
            end
        end
        // write and read of the same index in one cycle
        wr(6, VSEL_MDATA);
        dp.writenum = 3'd6;
        dp.readnum  = 3'd6;
        dp.vsel     = VSEL_IMM8;
        dp.write    = 1'b1;
        dp.loada    = 1'b1;
        tick();
        dp.write    = 1'b0;
        dp.loada    = 1'b0;
        dp.vsel     = '0;
        exp_q.push_back('{c: 16'd54, z: 1'b0, n: 1'b0, v: 1'b0});
        dp.sximm5 = '0;
        op(ALU_ADD, SH_PASS, 1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (dp.datapath_out !== e.c) begin
            bad++;
            $display("FAIL wr_rd_old got=%h exp=%h", dp.datapath_out, e.c);
        end
        exp_q.push_back('{c: 16'd72, z: 1'b0, n: 1'b0, v: 1'b0});
        rd_to_c(6);
        e = exp_q.pop_front();
        total++;
        if (dp.datapath_out !== e.c) begin
            bad++;
            $display("FAIL wr_rd_new got=%h exp=%h", dp.datapath_out, e.c);
        end
    endtask

    task automatic test_add_sub();
        exp_t e;
        dp.mdata = 16'hFFFC; wr(1, VSEL_MDATA);
        dp.mdata = 16'h0007; wr(3, VSEL_MDATA);
        lda(1);
        ldb(3);
        exp_q.push_back('{c: 16'hFFFF, z: 1'b0, n: 1'b1, v: 1'b0});
        op(ALU_ADD, SH_LSR, 1'b0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        total++;
        if ({dp.datapath_out, dp.Z_out, dp.N_out, dp.V_out} !== e) begin
            bad++;
            $display("FAIL add_lsr got=%h/%b exp=%h/%b", dp.datapath_out,
                     {dp.Z_out, dp.N_out, dp.V_out}, e.c, {e.z, e.n, e.v});
        end
        dp.mdata = 16'h7FFC; wr(1, VSEL_MDATA);
        dp.mdata = 16'h8007; wr(2, VSEL_MDATA);
        lda(1);
        ldb(2);
        exp_q.push_back('{c: 16'hFFF5, z: 1'b0, n: 1'b1, v: 1'b1});
        op(ALU_SUB, SH_PASS, 1'b0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        total++;
        if ({dp.datapath_out, dp.Z_out, dp.N_out, dp.V_out} !== e) begin
            bad++;
            $display("FAIL sub_ovf got=%h/%b exp=%h/%b", dp.datapath_out,
                     {dp.Z_out, dp.N_out, dp.V_out}, e.c, {e.z, e.n, e.v});
        end
        dp.mdata = 16'h0055; wr(1, VSEL_MDATA);
        lda(1);
        ldb(1);
        exp_q.push_back('{c: 16'h0000, z: 1'b1, n: 1'b0, v: 1'b0});
        op(ALU_SUB, SH_PASS, 1'b0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        total++;
        if ({dp.datapath_out, dp.Z_out, dp.N_out, dp.V_out} !== e) begin
            bad++;
            $display("FAIL sub_zero got=%h/%b exp=%h/%b", dp.datapath_out,
                     {dp.Z_out, dp.N_out, dp.V_out}, e.c, {e.z, e.n, e.v});
        end
    endtask

    task automatic test_logic();
        exp_t e;
        logic [W-1:0] a, b, r;
        logic [2:0]   ops [6];
        logic [1:0]   shs [6];
        logic         abs [6];
        a = 16'hF0F5;
        b = 16'h8C31;
        ops = '{ALU_OR, ALU_XOR, ALU_AND, ALU_MVN, ALU_ZERO, ALU_OR};
        shs = '{SH_PASS, SH_LSL, SH_ASR, SH_LSR, SH_PASS, SH_PASS};
        abs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dp.mdata = a; wr(1, VSEL_MDATA);
        dp.mdata = b; wr(2, VSEL_MDATA);
        lda(1);
        ldb(2);
        dp.sximm5 = 16'hFFF0;
        for (int i = 0; i < 6; i++) begin
            r = model(ops[i], shs[i], abs[i], abs[i], a, b, 16'hFFF0);
            exp_q.push_back('{c: r, z: (r == '0), n: r[W-1], v: 1'b0});
            op(ops[i], shs[i], abs[i], abs[i], 1'b1);
            e = exp_q.pop_front();
            total++;
            if ({dp.datapath_out, dp.Z_out, dp.N_out, dp.V_out} !== e) begin
                bad++;
                $display("FAIL logic_%0d got=%h/%b exp=%h/%b", i, dp.datapath_out,
                         {dp.Z_out, dp.N_out, dp.V_out}, e.c, {e.z, e.n, e.v});
            end
        end
    endtask

    task automatic test_mul_back_to_back();
        exp_t e;
        int   n;
        dp.mdata = 16'h0012; wr(1, VSEL_MDATA);
        dp.mdata = 16'h0034; wr(2, VSEL_MDATA);
        dp.mdata = 16'h0100; wr(4, VSEL_MDATA);
        lda(1);
        ldb(2);
        op(ALU_AND, SH_PASS, 1'b0, 1'b0, 1'b1);   // C = 0x0010, flags 000
        exp_q.push_back('{c: 16'h03A8, z: 1'b0, n: 1'b0, v: 1'b0});
        dp.ALUop = ALU_MUL; dp.loads = 1'b1; dp.loadc = 1'b1;
        tick();
        dp.ALUop = ALU_SUB;                       // must be ignored while busy
        n = 0;
        for (int cyc = 0; cyc < 40 && dp.busy === 1'b1; cyc++) begin
            n++;
            total++;
            if ({dp.datapath_out, dp.Z_out, dp.N_out, dp.V_out, dp.done} !== {16'h0010, 4'b0000}) begin
                bad++;
                $display("FAIL mul_hold_%0d got=%h/%b exp=0010/0000", n, dp.datapath_out,
                         {dp.Z_out, dp.N_out, dp.V_out, dp.done});
            end
            dp.readnum = 3'd4;
            dp.loada   = (n == 3);
            dp.loadb   = (n == 3);
            tick();
        end
        dp.loada = 1'b0;
        dp.loadb = 1'b0;
        total++;
        if (n !== 16) begin
            bad++;
            $display("FAIL mul_busy_cycles got=%0d exp=16", n);
        end
        total++;
        if (dp.done !== 1'b1) begin
            bad++;
            $display("FAIL mul_done got=%b exp=1", dp.done);
        end
        e = exp_q.pop_front();
        total++;
        if ({dp.datapath_out, dp.Z_out, dp.N_out, dp.V_out} !== e) begin
            bad++;
            $display("FAIL mul_result got=%h/%b exp=%h/%b", dp.datapath_out,
                     {dp.Z_out, dp.N_out, dp.V_out}, e.c, {e.z, e.n, e.v});
        end
        // start the next multiply in the done cycle
        exp_q.push_back('{c: 16'h0000, z: 1'b1, n: 1'b0, v: 1'b1});
        dp.ALUop = ALU_MUL;
        tick();
        dp.loadc = 1'b0;
        dp.loads = 1'b0;
        total++;
        if ({dp.busy, dp.done} !== 2'b10) begin
            bad++;
            $display("FAIL mul2_start got=%b exp=10", {dp.busy, dp.done});
        end
        n = 0;
        for (int cyc = 0; cyc < 40 && dp.busy === 1'b1; cyc++) begin
            n++;
            tick();
        end
        total++;
        if (n !== 16 || dp.done !== 1'b1) begin
            bad++;
            $display("FAIL mul2_busy_done got=%0d/%b exp=16/1", n, dp.done);
        end
        e = exp_q.pop_front();
        total++;
        if ({dp.datapath_out, dp.Z_out, dp.N_out, dp.V_out} !== e) begin
            bad++;
            $display("FAIL mul2_result got=%h/%b exp=%h/%b", dp.datapath_out,
                     {dp.Z_out, dp.N_out, dp.V_out}, e.c, {e.z, e.n, e.v});
        end
        tick();
        total++;
        if (dp.done !== 1'b0) begin
            bad++;
            $display("FAIL mul2_done_pulse got=%b exp=0", dp.done);
        end
    endtask

    task automatic test_mul_reset();
        exp_t e;
        int   n;
        int   pulses;
        op(ALU_ADD, SH_PASS, 1'b0, 1'b0, 1'b0);   // C = 0x0200
        op(ALU_MUL, SH_PASS, 1'b0, 1'b0, 1'b1);   // now in busy cycle 1
        for (int i = 0; i < 4; i++) tick();      // busy cycle 5
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({dp.busy, dp.done, dp.datapath_out} !== {2'b00, 16'h0000}) begin
            bad++;
            $display("FAIL mul_abort got=%b%b/%h exp=00/0000", dp.busy, dp.done, dp.datapath_out);
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (dp.done !== 1'b0) pulses++;
            tick();
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL mul_abort_no_done got=%0d exp=0", pulses);
        end
        dp.mdata = 16'h0123; wr(1, VSEL_MDATA);
        dp.mdata = 16'h0081; wr(2, VSEL_MDATA);
        lda(1);
        ldb(2);
        exp_q.push_back('{c: 16'h92A3, z: 1'b0, n: 1'b1, v: 1'b0});
        op(ALU_MUL, SH_PASS, 1'b0, 1'b0, 1'b1);
        n = 0;
        for (int cyc = 0; cyc < 40 && dp.busy === 1'b1; cyc++) begin
            n++;
            tick();
        end
        total++;
        if (n !== 16 || dp.done !== 1'b1) begin
            bad++;
            $display("FAIL mul3_busy_done got=%0d/%b exp=16/1", n, dp.done);
        end
        e = exp_q.pop_front();
        total++;
        if ({dp.datapath_out, dp.Z_out, dp.N_out, dp.V_out} !== e) begin
            bad++;
            $display("FAIL mul3_result got=%h/%b exp=%h/%b", dp.datapath_out,
                     {dp.Z_out, dp.N_out, dp.V_out}, e.c, {e.z, e.n, e.v});
        end
    endtask

    initial begin
        reset       = 1'b1;
        dp.readnum  = '0;
        dp.writenum = '0;
        dp.write    = 1'b0;
        dp.vsel     = '0;
        dp.loada    = 1'b0;
        dp.loadb    = 1'b0;
        dp.asel     = 1'b0;
        dp.bsel     = 1'b0;
        dp.shift    = '0;
        dp.ALUop    = '0;
        dp.loadc    = 1'b0;
        dp.loads    = 1'b0;
        dp.sximm8   = '0;
        dp.sximm5   = '0;
        dp.mdata    = '0;
        dp.PC       = '0;
        tick();
        reset = 1'b0;
        test_reset();
        test_vsel();
        test_add_sub();
        test_logic();
        test_mul_back_to_back();
        test_mul_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/datapath_param.md
Name: datapath_param

Overview:
Parametrised successor to the lab datapath. It contains the register file, the A/B/C operand and result registers, the shifter, an extended ALU, and the Z/N/V status register. It adds a synchronous reset, configurable word width and register count, OR/XOR operations, and a multi-cycle iterative multiply with busy/done handshake. The controller FSM drives it using the existing control-signal set.

Parameters:
WIDTH, 16, datapath word width in bits (≥8)
NREGS, 8, number of general registers (power of two, ≥2)
PC_W, 9, program-counter width (PC_W ≤ WIDTH)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
readnum  in  log2(NREGS)  register read index
writenum  in  log2(NREGS)  register write index
write  in  1  register-file write enable
vsel  in  4  one-hot write-data select
loada, loadb  in  1  load A / load B from read port
asel, bsel  in  1  1 = Ain zero / Bin sximm5
shift  in  2  shifter op on B path
ALUop  in  3  ALU operation
loadc  in  1  load C / start multiply
loads  in  1  load status
sximm8, sximm5, mdata  in  WIDTH  immediate and memory data
PC  in  PC_W  program counter
datapath_out  out  WIDTH  C register
Z_out, N_out, V_out  out  1  status flags
busy  out  1  multiply in progress
done  out  1  one-cycle pulse when a multiply result is written to C

Behaviour:
- Reset (sync, high): all registers R0..R(NREGS-1), A, B, C, Z/N/V, busy, done = 0. Any in-flight multiply is aborted with no done pulse. Reset overrides all other inputs.
- data_in mux:
  - 1000 → mdata; 0100 → sximm8; 0010 → zero-extended PC; 0001 → datapath_out.
  - Any non-one-hot vsel → 0.
- Register file: read is combinational on readnum. Write occurs at the edge when write=1. Write-and-read of the same index in one cycle returns the old value; the new value is visible after the edge.
- A/B: load from the read port at the edge when loada/loadb=1. Loads are permitted while busy.
- Ain = asel ? 0 : A. Bin = bsel ? sximm5 : shifted B.
- shift: 00 pass; 01 left 1 with 0 fill; 10 logical right 1; 11 arithmetic right 1.
- ALUop:
  - 000 ADD; 001 SUB (Ain−Bin); 010 AND; 011 MVN (~Bin).
  - 100 OR; 101 XOR; 110 MUL; 111 → result 0.
  - All results are WIDTH bits, modulo 2^WIDTH.
- Status flags:
  - Z = (result==0); N = result[WIDTH-1].
  - V = signed overflow for ADD/SUB.
  - V = 1 for MUL if the unsigned 2·WIDTH product has any nonzero upper half.
  - V = 0 for all other ops.
- Single-cycle ops: with loadc=1 and busy=0, C loads at that edge (latency 1). Status loads at the same edge if loads=1.
- MUL FSM: IDLE → RUN → IDLE.
  - IDLE: loadc=1 with ALUop=110 latches Ain, Bin, and loads, clears the accumulator, and sets busy=1 at that edge.
  - RUN: shift-add one bit per cycle for exactly WIDTH cycles. At edge start+WIDTH: C ← low half; status ← flags if latched loads=1; busy ← 0; done ← 1 for one cycle; return to IDLE.
  - While busy: loadc/loads are ignored (any op), C and status hold, and datapath_out shows the old C. Register writes, including vsel=0001, proceed normally.
  - A new MUL may start in the cycle done=1, because busy is already 0.
- No combinational path from inputs to busy/done.

Decomposition:
- Package datapath_pkg: ALUop codes (ALU_ADD..ALU_MUL), shift codes, vsel one-hot constants, and the mul FSM state enum.
- One sub-module, seq_mul: the WIDTH-parametrised iterative multiplier. It has start, op_a, op_b, busy, done, product_lo, and ovf outputs, and takes clk/reset.
- Register file, shifter, and ALU stay inline.

Test Plan:
1. Reset for 1 cycle after random activity → datapath_out=0, Z=N=V=0, busy=0, all Rn=0.
2. vsel sweep with mdata=54, sximm8=72, PC=20 → data_in 54, 72, 20, then datapath_out; vsel=0011 → data_in=0.
3. R1=0xFFFC, R3=0x0007, A=R1, B=R3, shift=10, ADD, loadc=loads=1 → C=0xFFFF, Z=0, N=1, V=0.
4. A=0x7FFC, B=0x8007, SUB → C=0xFFF5, N=1, V=1, Z=0. Then A=B=0x0055, SUB → C=0, Z=1, N=0, V=0.
5. MUL A=0x0012, B=0x0034 → busy high exactly 16 cycles, loadc ignored meanwhile, done pulse, C=0x03A8, V=0. Then A=B=0x0100 → C=0, Z=1, V=1.
6. Reset asserted on the 5th busy cycle of a MUL → next edge busy=0, C=0, no done pulse. A following MUL completes correctly.
